roulette_round_ctrl: RTL
========================

// Module: roulette_round_ctrl
// PURPOSE
//  Round sequencer for the roulette game datapath. Edge-detects the start key and latches the
//  player's guess and game mode. Runs a fixed-length spin window, then samples the free-running
//  random number and judges the round. Owns the player balance and the win/lose/game-over flags
//  that drive the HEX and LED outputs. Mode 0 is even/odd betting; mode 1 is exact-number betting.
// PARAMETERS
//  BAL_W        5    balance width (bits)
//  START_BAL    10   balance loaded on reset/new game; must satisfy 0 < START_BAL < WIN_BAL
//  WIN_BAL      20   balance >= WIN_BAL after a round -> game won
//  EO_PAY       2    even/odd win payout
//  EXACT_PAY    8    exact-number win payout
//  LOSE_COST    1    amount deducted on a lost round
//  SPIN_CYCLES  8    cycles spent in SPIN (>= 1)
// PORTS
//  Clock        in   1      system clock
//  reset_n      in   1      asynchronous active-low reset
//  start_n      in   1      start key, active-low, already synchronised to Clock
//  new_game     in   1      1-cycle pulse: reload balance, clear flags, return to IDLE
//  mode         in   1      0 = even/odd bet, 1 = exact-number bet (latched at round start)
//  player_guess in   5      mode 0: bit0=1 even, bit0=0 odd; mode 1: number 0..31
//  rand_num     in   5      free-running random number
//  balance      out  BAL_W  current player balance
//  drawn        out  5      number drawn in last round
//  round_win    out  1      last judged round was won (held until next round starts)
//  round_lose   out  1      last judged round was lost (held until next round starts)
//  game_won     out  1      high in WON state
//  game_lost    out  1      high in LOST state
//  busy         out  1      high in SPIN and JUDGE
// BEHAVIOUR
//  Reset (async): state=IDLE, balance=START_BAL, drawn=0, all flags 0, start_q=1, cnt=0.
//  start_fall = start_q & ~start_n; start_q <= start_n every cycle.
//  States: IDLE, SPIN, JUDGE, WON, LOST (3-bit encoding).
//  - IDLE: on start_fall latch guess_q<=player_guess, mode_q<=mode, clear round_win/round_lose,
//    cnt<=0, go to SPIN. A start_fall in any other state is ignored.
//  - SPIN: cnt increments each cycle. At cnt==SPIN_CYCLES-1: drawn<=rand_num, go to JUDGE.
//  - JUDGE (1 cycle): win = mode_q ? (drawn==guess_q) : (drawn[0] == ~guess_q[0]).
//    On win: balance <= min(balance+pay, 2^BAL_W-1), where pay = mode_q ? EXACT_PAY : EO_PAY.
//    On loss: balance <= (balance>LOSE_COST) ? balance-LOSE_COST : 0.
//    Set round_win/round_lose. Next state: WON if new balance >= WIN_BAL; else LOST if new
//    balance == 0; else IDLE. Compute the sum at BAL_W+1 bits; no wrap-around.
//  - WON / LOST: terminal. Balance is frozen and start_n is ignored. Exit only via new_game
//    or reset.
//  Latency: the edge that detects start_fall enters SPIN. The balance and flags update
//    SPIN_CYCLES+1 edges later (on the edge leaving JUDGE).
//  new_game has priority over everything and is valid in any state, including mid-SPIN:
//    state=IDLE, balance=START_BAL, all flags 0, drawn unchanged. A start_fall in the same
//    cycle is dropped.
//  Holding start_n low yields exactly one round; a new fall requires start_n to rise first.
//  Asserting reset_n mid-round aborts the round with no balance change beyond the reset load.
// TESTING
//  1. Reset, mode 0, guess bit0=1, rand_num=6, start fall -> after 9 cycles balance=12,
//     round_win=1, drawn=6, state IDLE.
//  2. Mode 0, guess odd, rand_num=6 -> balance 10->9, round_lose=1. Repeat ten losses ->
//     balance=0, game_lost=1; a further start fall changes nothing.
//  3. Mode 1, guess 17, rand_num=17, balance 14 -> balance 22, game_won=1, busy=0;
//     new_game -> balance 10, all flags 0.
//  4. start_n held low for 50 cycles -> exactly one round judged; busy high for exactly 9 cycles.
//  5. new_game pulse at SPIN cycle 4 -> IDLE next cycle, balance=10, no JUDGE occurs.
//  6. BAL_W=5, WIN_BAL=31, balance 28, exact win (+8) -> balance saturates at 31, game_won=1;
//     reset_n low mid-SPIN -> IDLE, balance=START_BAL immediately.

Source files
------------

// File: rtl/roulette_round_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// roulette_round_ctrl
// Round sequencer for the roulette game datapath. A falling edge on the
// start key latches the bet, runs a fixed spin window, samples the
// free-running random number and judges the round against the bet. Owns the
// player balance and the round / game status flags.
//
// Ports
//   Clock         system clock
//   reset_n       asynchronous active-low reset
//   start_n       start key, active-low, already synchronised to Clock
//   new_game      1-cycle pulse: reload balance, clear flags, back to IDLE
//   mode          0 = even/odd bet, 1 = exact-number bet (latched at start)
//   player_guess  mode 0: bit0=1 even / bit0=0 odd; mode 1: number 0..31
//   rand_num      free-running random number
//   balance       current player balance
//   drawn         number drawn in the last round
//   round_win     last judged round was won (held until next round starts)
//   round_lose    last judged round was lost (held until next round starts)
//   game_won      high in WON
//   game_lost     high in LOST
//   busy          high in SPIN and JUDGE
// ---------------------------------------------------------------------------
module roulette_round_ctrl #(
   parameter  int unsigned BAL_W       = 5,
   parameter  int unsigned START_BAL   = 10,
   parameter  int unsigned WIN_BAL     = 20,
   parameter  int unsigned EO_PAY      = 2,
   parameter  int unsigned EXACT_PAY   = 8,
   parameter  int unsigned LOSE_COST   = 1,
   parameter  int unsigned SPIN_CYCLES = 8,
   localparam int unsigned NUM_W       = 5
) (
   input  logic             Clock,
   input  logic             reset_n,
   input  logic             start_n,
   input  logic             new_game,
   input  logic             mode,
   input  logic [NUM_W-1:0] player_guess,
   input  logic [NUM_W-1:0] rand_num,
   output logic [BAL_W-1:0] balance,
   output logic [NUM_W-1:0] drawn,
   output logic             round_win,
   output logic             round_lose,
   output logic             game_won,
   output logic             game_lost,
   output logic             busy
);

   localparam int unsigned CNT_W = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
   localparam int unsigned SUM_W = BAL_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SPIN  = 3'd1,
      ST_JUDGE = 3'd2,
      ST_WON   = 3'd3,
      ST_LOST  = 3'd4
   } state_e;

   state_e             state_q,   state_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic               start_q;
   logic [NUM_W-1:0]   guess_q,   guess_d;
   logic               mode_q,    mode_d;
   logic [BAL_W-1:0]   balance_q, balance_d;
   logic [NUM_W-1:0]   drawn_q,   drawn_d;
   logic               win_q,     win_d;
   logic               lose_q,    lose_d;
   logic               won_q,     won_d;
   logic               lost_q,    lost_d;
   logic               busy_q,    busy_d;

   logic               start_fall_c;
   logic               win_c;
   logic [SUM_W-1:0]   pay_c;
   logic [SUM_W-1:0]   sum_c;
   logic [BAL_W-1:0]   new_bal_c;
   state_e             judge_next_c;

   // Start key falling edge; the previous level is sampled every cycle.
   assign start_fall_c = start_q & ~start_n;

   // Round judgement, only consumed in JUDGE.
   // An even/odd bet wins when the drawn parity matches the guessed one
   // (guess bit0=1 means even, i.e. drawn bit0 must be 0).
   always_comb begin
      win_c        = mode_q ? (drawn_q == guess_q) : (drawn_q[0] == ~guess_q[0]);
      pay_c        = mode_q ? SUM_W'(EXACT_PAY) : SUM_W'(EO_PAY);
      sum_c        = {1'b0, balance_q} + pay_c;
      new_bal_c    = balance_q;
      judge_next_c = ST_IDLE;
      if (win_c) begin
         // Sum is one bit wider than the balance so the saturation test sees the carry.
         new_bal_c = sum_c[BAL_W] ? {BAL_W{1'b1}} : sum_c[BAL_W-1:0];
      end else begin
         new_bal_c = (balance_q > BAL_W'(LOSE_COST)) ? (balance_q - BAL_W'(LOSE_COST))
                                                    : '0;
      end
      if ({1'b0, new_bal_c} >= SUM_W'(WIN_BAL)) begin
         judge_next_c = ST_WON;
      end else if (new_bal_c == '0) begin
         judge_next_c = ST_LOST;
      end
   end

   // Next-state and register-input logic; new_game overrides every state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      guess_d   = guess_q;
      mode_d    = mode_q;
      balance_d = balance_q;
      drawn_d   = drawn_q;
      win_d     = win_q;
      lose_d    = lose_q;

      if (new_game) begin
         // A start fall in the same cycle is dropped; drawn is kept.
         state_d   = ST_IDLE;
         cnt_d     = '0;
         balance_d = BAL_W'(START_BAL);
         win_d     = 1'b0;
         lose_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_fall_c) begin
                  guess_d = player_guess;
                  mode_d  = mode;
                  win_d   = 1'b0;
                  lose_d  = 1'b0;
                  cnt_d   = '0;
                  state_d = ST_SPIN;
               end
            end
            ST_SPIN: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(SPIN_CYCLES - 1)) begin
                  drawn_d = rand_num;
                  state_d = ST_JUDGE;
               end
            end
            ST_JUDGE: begin
               balance_d = new_bal_c;
               win_d     = win_c;
               lose_d    = ~win_c;
               state_d   = judge_next_c;
            end
            ST_WON, ST_LOST: begin
               // Terminal: balance frozen, start key ignored.
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Status outputs are registered from the next state so they align with it.
      won_d  = (state_d == ST_WON);
      lost_d = (state_d == ST_LOST);
      busy_d = (state_d == ST_SPIN) || (state_d == ST_JUDGE);
   end

   // State and datapath registers.
   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         start_q   <= 1'b1;
         guess_q   <= '0;
         mode_q    <= 1'b0;
         balance_q <= BAL_W'(START_BAL);
         drawn_q   <= '0;
         win_q     <= 1'b0;
         lose_q    <= 1'b0;
         won_q     <= 1'b0;
         lost_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         start_q   <= start_n;
         guess_q   <= guess_d;
         mode_q    <= mode_d;
         balance_q <= balance_d;
         drawn_q   <= drawn_d;
         win_q     <= win_d;
         lose_q    <= lose_d;
         won_q     <= won_d;
         lost_q    <= lost_d;
         busy_q    <= busy_d;
      end
   end

   assign balance    = balance_q;
   assign drawn      = drawn_q;
   assign round_win  = win_q;
   assign round_lose = lose_q;
   assign game_won   = won_q;
   assign game_lost  = lost_q;
   assign busy       = busy_q;

endmodule
